fifo_wr_arbiter: RTL

Write-side arbiter that shares the single push port of the dual-clock FIFO among `N_REQ` requesters in the FIFO write clock domain. Grants the port round-robin, one packet at a time, and drives `push`/`data_in` directly from the owning requester while honouring `full`. Sits between the producer blocks and the FIFO's provider-side write signals.

---
 rtl/fifo_wr_arbiter_pkg.sv | 13 +
 rtl/fifo_wr_arbiter_rr_picker.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types for the FIFO write-side arbiter
package fifo_wr_arbiter_pkg;

   localparam int DATA_W = 8;

   typedef logic [DATA_W-1:0] data_ty;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rtl/fifo_wr_arbiter_rr_picker.sv - round-robin index picker starting at a pointer
module rr_picker
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int  N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   // scan from ptr_i upward with wrap; the first requesting index wins
   always_comb begin
      logic [IDX_W-1:0] j;
      found_o = 1'b0;
      idx_o   = '0;
      j       = ptr_i;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found_o && req_i[j]) begin
            found_o = 1'b1;
            idx_o   = j;
         end
         j = (j == IDX_W'(N_REQ - 1)) ? '0 : j + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin packet arbiter for the FIFO write port
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int  N_REQ     = 4,
   parameter int  MAX_BEATS = 16,
   localparam int IDX_W     = $clog2(N_REQ),
   localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
   input  logic               wrclk,
   input  logic               wr_rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  data_ty [N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   input  logic               full,
   output logic               push,
   output data_ty             data_in,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               len_err
);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;     // first index scanned at the next arbitration
   logic [CNT_W-1:0] cnt_q, cnt_d;     // beats accepted in the current grant
   logic             len_err_q, len_err_d;

   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic             release_now;

   rr_picker #(
      .N_REQ (N_REQ)
   ) u_picker (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // next-state, beat counting and the combinational push/ready path
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      len_err_d   = 1'b0;
      req_ready   = '0;
      push        = 1'b0;
      release_now = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = LOCK;
               owner_d = pick_idx;
            end
         end
         LOCK: begin
            // ready is gated by reset too, so a requester never sees a beat
            // taken in the cycle the packet is being abandoned
            req_ready[owner_q] = !full && !wr_rst;
            push               = req_valid[owner_q] && !full && !wr_rst;
            if (push) begin
               release_now = req_last[owner_q] ||
                             (cnt_q + 1'b1 == CNT_W'(MAX_BEATS));
               if (release_now) begin
                  state_d   = IDLE;
                  cnt_d     = '0;
                  ptr_d     = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                  len_err_d = !req_last[owner_q];
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state registers with synchronous active-high reset
   always_ff @(posedge wrclk) begin
      if (wr_rst) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         len_err_q <= len_err_d;
      end
   end

   assign data_in     = req_data[owner_q];
   assign grant_valid = (state_q == LOCK);
   assign grant_idx   = owner_q;
   assign len_err     = len_err_q;

endmodule
